// File: rtl/prog_loader_if.sv
// Host byte stream plus the loader's dedicated write port into the shared program RAM.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              byte_ready;
  logic              ram_sel;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, ram_sel, ram_addr, ram_data, ram_wren
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, ram_sel, ram_addr, ram_data, ram_wren
  );
endinterface

// File: rtl/prog_loader.sv
// Streams host bytes into program RAM while holding the core, then fires a one-cycle run pulse.
// All outputs are flops; the byte-accept path feeds a one-cycle registered write.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  prog_loader_if.slave      bus,
  output logic              halt,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FLUSH  = 2'd2,
    LAUNCH = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] b);
    return acc + b;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              sel_q, sel_d;
  logic              halt_q, halt_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              run_q, run_d;
  logic              accept_s;
  logic              last_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    csum_d  = csum_q;
    done_d  = done_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;

    accept_s = (state_q == LOAD) && bus.byte_valid;
    last_s   = accept_s && ((cnt_q + CNT_ONE) == len_q);
    wren_d   = accept_s;

    if (accept_s) begin
      addr_d = ptr_q;
      data_d = bus.byte_data;
      ptr_d  = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      cnt_d  = cnt_q + CNT_ONE;
      csum_d = csum_add(csum_q, bus.byte_data);
    end else begin
      wren_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = start_addr;
          // len of zero encodes a full 256-byte image
          len_d   = (len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len};
          cnt_d   = '0;
          csum_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (last_s) begin
          state_d = FLUSH;
        end else begin
          state_d = LOAD;
        end
      end
      FLUSH: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    halt_d  = (state_d == LOAD) || (state_d == FLUSH);
    // A byte taken alongside abort still gets its write cycle with the port owned.
    sel_d   = halt_d || accept_s;
    ready_d = (state_d == LOAD);
    run_d   = (state_d == LAUNCH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      sel_q   <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      sel_q   <= sel_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      run_q   <= run_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.ram_sel    = sel_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_data   = data_q;
  assign bus.ram_wren   = wren_q;
  assign halt           = halt_q;
  assign run            = run_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign checksum       = csum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stimulus pushes expected RAM writes, a negedge monitor pops them.
module tb_prog_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] len;
  logic       abort;
  logic       halt;
  logic       run;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] checksum;

  prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .abort      (abort),
    .bus        (bus.slave),
    .halt       (halt),
    .run        (run),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          run_count    = 0;
  logic [15:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (run) run_count++;
    if (bus.ram_wren) begin
      check("wren_with_sel", {31'd0, bus.ram_sel}, 32'd1);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.ram_addr, bus.ram_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {24'd0, bus.ram_addr}, {24'd0, e[15:8]});
        check("write_data", {24'd0, bus.ram_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, bus.ram_sel, bus.ram_wren, halt, run, busy, done, err, bus.byte_ready,
            checksum, bus.ram_addr == 8'd0 && bus.ram_data == 8'd0 ? 8'd0 : 8'hFF};
  endfunction

  task automatic do_start(input logic [7:0] a, input logic [7:0] l);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_after_start", {31'd0, bus.byte_ready}, 32'd1);
    check("halt_after_start", {31'd0, halt}, 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    exp_q.push_back({a, d});
    tick();
    bus.byte_valid = 1'b0;
  endtask

  // Entered one cycle after the last acceptance (FLUSH).
  task automatic finish_load(input logic [7:0] exp_csum);
    int rc0;
    rc0 = run_count;
    check("flush_busy", {31'd0, busy}, 32'd1);
    check("flush_halt", {31'd0, halt}, 32'd1);
    check("flush_sel", {31'd0, bus.ram_sel}, 32'd1);
    check("flush_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("flush_run", {31'd0, run}, 32'd0);
    tick();
    check("launch_run", {31'd0, run}, 32'd1);
    check("launch_halt", {31'd0, halt}, 32'd0);
    check("launch_sel", {31'd0, bus.ram_sel}, 32'd0);
    tick();
    check("idle_run", {31'd0, run}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_err", {31'd0, err}, 32'd0);
    check("checksum", {24'd0, checksum}, {24'd0, exp_csum});
    check("run_pulses", run_count - rc0, 32'd1);
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int rc0;
    rst            = 1'b0;
    start          = 1'b0;
    start_addr     = 8'd0;
    len            = 8'd0;
    abort          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    repeat (2) tick();
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    tick();

    // Basic load
    do_start(8'h10, 8'd4);
    send(8'h50, 8'h10);
    send(8'h01, 8'h11);
    send(8'hA5, 8'h12);
    send(8'h0F, 8'h13);
    finish_load(8'h05);

    // Address wrap with gaps in byte_valid
    do_start(8'hFE, 8'd3);
    send(8'h11, 8'hFE);
    tick();
    send(8'h22, 8'hFF);
    tick();
    tick();
    send(8'h33, 8'h00);
    finish_load(8'h66);

    // Full 256-byte image
    do_start(8'h00, 8'd0);
    for (int i = 0; i < 256; i++) begin
      send(i[7:0], i[7:0]);
      if (i == 254) begin
        check("full_still_loading", {31'd0, bus.byte_ready}, 32'd1);
      end
    end
    finish_load(8'h80);

    // Abort concurrent with the second of five bytes
    rc0 = run_count;
    do_start(8'h40, 8'd5);
    send(8'hAA, 8'h40);
    abort = 1'b1;
    send(8'hBB, 8'h41);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_halt", {31'd0, halt}, 32'd0);
    check("abort_drain_sel", {31'd0, bus.ram_sel}, 32'd1);
    check("abort_drain_wren", {31'd0, bus.ram_wren}, 32'd1);
    check("abort_err", {31'd0, err}, 32'd1);
    tick();
    check("abort_sel_dropped", {31'd0, bus.ram_sel}, 32'd0);
    check("abort_no_wren", {31'd0, bus.ram_wren}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_checksum", {24'd0, checksum}, 32'h65);
    check("abort_no_run", run_count - rc0, 32'd0);
    check("abort_writes_drained", exp_q.size(), 32'd0);

    // New start clears err; abort during FLUSH
    do_start(8'h7F, 8'd1);
    check("start_clears_err", {31'd0, err}, 32'd0);
    check("start_clears_csum", {24'd0, checksum}, 32'd0);
    send(8'h5A, 8'h7F);
    abort = 1'b1;
    check("flush_abort_wren", {31'd0, bus.ram_wren}, 32'd1);
    tick();
    abort = 1'b0;
    check("flush_abort_busy", {31'd0, busy}, 32'd0);
    check("flush_abort_run", {31'd0, run}, 32'd0);
    check("flush_abort_err", {31'd0, err}, 32'd1);
    check("flush_abort_sel", {31'd0, bus.ram_sel}, 32'd0);
    tick();
    check("flush_abort_no_run", run_count - rc0, 32'd0);

    // start ignored during LOAD; byte_valid ignored in IDLE
    do_start(8'h20, 8'd2);
    send(8'h01, 8'h20);
    start      = 1'b1;
    start_addr = 8'h90;
    len        = 8'd7;
    send(8'h02, 8'h21);
    start = 1'b0;
    finish_load(8'h03);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    repeat (3) tick();
    bus.byte_valid = 1'b0;
    check("idle_valid_csum", {24'd0, checksum}, 32'h03);
    check("idle_valid_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("idle_valid_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a load
    do_start(8'h80, 8'd4);
    send(8'h10, 8'h80);
    send(8'h20, 8'h81);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 32'd0);
    start          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h77;
    repeat (3) tick();
    check("held_reset_outputs", all_outs(), 32'd0);
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_drained", exp_q.size(), 32'd0);

    // Recovery: a fresh load after reset
    do_start(8'hC0, 8'd2);
    send(8'h0A, 8'hC0);
    send(8'h0B, 8'hC1);
    finish_load(8'h15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
